// File: rtl/ascon_hash_padder.sv
// ---------------------------------------------------------------------------
// ascon_hash_padder
//   Upstream feeder for the Ascon-Hash sequencer. Takes a message as a byte
//   stream and packs it into 64-bit rate blocks, MSB-first. Padding is always
//   applied: one 0x80 byte, then zeros up to the next 64-bit boundary. A
//   message whose length is a multiple of 8 bytes therefore gains one extra
//   block holding only the pad.
//
// Optional feature: define ASCON_PAD_LEN_EN to enable the message byte
//   counter (msg_bytes) and its sticky saturation flag (len_ovf). With the
//   macro undefined, both outputs are tied to zero.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   s_data     message byte
//   s_valid    s_data/s_last/s_empty are valid
//   s_last     beat ends the message
//   s_empty    beat carries no data byte (meaningful together with s_last)
//   s_ready    padder accepts a beat (only while filling a block)
//   m_block    rate block, first message byte in [63:56]
//   m_valid    m_block is valid
//   m_last     m_block is the final padded block of the message
//   m_ready    downstream takes the block
//   msg_bytes  data bytes of the current/last message (ASCON_PAD_LEN_EN)
//   len_ovf    sticky byte-counter saturation flag (ASCON_PAD_LEN_EN)
// ---------------------------------------------------------------------------
module ascon_hash_padder #(
  parameter int RATE  = 64,  // rate in bits; only 64 is supported
  parameter int LEN_W = 32   // width of the message byte counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_empty,
  output logic             s_ready,
  output logic [RATE-1:0]  m_block,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [LEN_W-1:0] msg_bytes,
  output logic             len_ovf
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  localparam logic [RATE-1:0] PAD_BLOCK = {8'h80, {(RATE-8){1'b0}}};

  state_t          state_r;
  logic [2:0]      cnt_r;          // next free byte lane
  logic [RATE-1:0] buf_r;          // partially filled block
  logic            pad_pending_r;  // full data block sent, pad-only block owed
  logic [RATE-1:0] fill_buf_s;     // buffer with the current beat merged in
  logic            accept_s;
  logic            full_s;         // data beat fills the last lane

  assign s_ready  = (state_r == ST_FILL);
  assign accept_s = s_valid && (state_r == ST_FILL);
  assign full_s   = !s_empty && (cnt_r == 3'd7);

  // Merge the incoming beat into the buffer: data goes to lane cnt, and on a
  // closing beat the 0x80 pad byte goes right after the data (or at lane cnt
  // for an empty closing beat). Lanes above are already zero in buf_r.
  always_comb begin
    fill_buf_s = buf_r;
    for (int i = 0; i < 8; i++) begin
      if (!s_empty && (cnt_r == i[2:0])) begin
        fill_buf_s[RATE-1-8*i -: 8] = s_data;
      end else if (s_last && s_empty && (cnt_r == i[2:0])) begin
        fill_buf_s[RATE-1-8*i -: 8] = 8'h80;
      end else if (s_last && !s_empty && (cnt_r != 3'd7) &&
                   ((cnt_r + 3'd1) == i[2:0])) begin
        fill_buf_s[RATE-1-8*i -: 8] = 8'h80;
      end else begin
        fill_buf_s[RATE-1-8*i -: 8] = buf_r[RATE-1-8*i -: 8];
      end
    end
  end

  // Packing FSM with registered block outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_FILL;
      cnt_r         <= 3'd0;
      buf_r         <= {RATE{1'b0}};
      pad_pending_r <= 1'b0;
      m_block       <= {RATE{1'b0}};
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            if (!s_empty && !s_last && (cnt_r != 3'd7)) begin
              buf_r <= fill_buf_s;
              cnt_r <= cnt_r + 3'd1;
            end else if (!s_empty || s_last) begin
              // Block closes: either all 8 lanes are full or the message ends.
              // A message ending exactly on a full block owes a pad block.
              m_block       <= fill_buf_s;
              m_valid       <= 1'b1;
              m_last        <= s_last && !full_s;
              pad_pending_r <= s_last && full_s;
              cnt_r         <= 3'd0;
              state_r       <= ST_EMIT;
            end else begin
              // Empty beat without s_last: consumed and ignored.
              cnt_r <= cnt_r;
            end
          end
        end
        ST_EMIT: begin
          if (m_ready) begin
            if (pad_pending_r) begin
              m_block       <= PAD_BLOCK;
              m_last        <= 1'b1;
              pad_pending_r <= 1'b0;
              state_r       <= ST_PAD;
            end else begin
              m_valid <= 1'b0;
              buf_r   <= {RATE{1'b0}};
              cnt_r   <= 3'd0;
              state_r <= ST_FILL;
            end
          end
        end
        ST_PAD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            buf_r   <= {RATE{1'b0}};
            cnt_r   <= 3'd0;
            state_r <= ST_FILL;
          end
        end
        default: begin
          m_valid       <= 1'b0;
          pad_pending_r <= 1'b0;
          buf_r         <= {RATE{1'b0}};
          cnt_r         <= 3'd0;
          state_r       <= ST_FILL;
        end
      endcase
    end
  end

`ifdef ASCON_PAD_LEN_EN
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  logic msg_start_r;  // next accepted beat opens a new message

  // Message byte counter: restarts on the first beat of each message,
  // saturates, and holds after the message completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_bytes   <= {LEN_W{1'b0}};
      len_ovf     <= 1'b0;
      msg_start_r <= 1'b1;
    end else if (accept_s) begin
      msg_start_r <= s_last;
      if (msg_start_r) begin
        msg_bytes <= s_empty ? {LEN_W{1'b0}} : LEN_W'(1'b1);
        len_ovf   <= 1'b0;
      end else if (!s_empty) begin
        if (msg_bytes == LEN_MAX) begin
          len_ovf <= 1'b1;
        end else begin
          msg_bytes <= msg_bytes + LEN_W'(1'b1);
        end
      end else begin
        msg_bytes <= msg_bytes;
      end
    end else begin
      msg_bytes <= msg_bytes;
    end
  end
`else
  assign msg_bytes = {LEN_W{1'b0}};
  assign len_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_hash_padder.sv
// ---------------------------------------------------------------------------
// tb_ascon_hash_padder
//   Self-checking bench for ascon_hash_padder. Directed messages use
//   hand-computed expected blocks; random messages are checked against a
//   byte-queue model (append 0x80, zero-fill to 8 bytes, split MSB-first).
//   A monitor compares every handshaken block against the expectation queue
//   and checks that a stalled block is held stable.
// ---------------------------------------------------------------------------
module tb_ascon_hash_padder;

  localparam int LEN_W = 32;

  typedef struct packed {
    logic [63:0] blk;
    logic        last;
    logic [31:0] len;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_empty = 1'b0;
  logic             s_ready;
  logic [63:0]      m_block;
  logic             m_valid;
  logic             m_last;
  logic             m_ready = 1'b0;
  logic [LEN_W-1:0] msg_bytes;
  logic             len_ovf;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;  // 0 random, 1 always ready, 2 held low
  exp_t exp_q[$];
  logic [7:0] msg_q[$];

  logic        prev_stall = 1'b0;
  logic [63:0] prev_blk = 64'h0;
  logic        prev_last = 1'b0;

  ascon_hash_padder #(.RATE(64), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_empty   (s_empty),
    .s_ready   (s_ready),
    .m_block   (m_block),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .msg_bytes (msg_bytes),
    .len_ovf   (len_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [63:0] blk, input logic last,
                          input int len);
    exp_t e;
    e.blk  = blk;
    e.last = last;
    e.len  = 32'(len);
    exp_q.push_back(e);
  endtask

  // Reference model: pad the byte queue and cut it into 64-bit blocks.
  task automatic model_msg();
    logic [7:0] p[$];
    logic [63:0] b;
    int n;
    n = msg_q.size();
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 8) != 0) p.push_back(8'h00);
    for (int k = 0; k < p.size() / 8; k++) begin
      b = 64'h0;
      for (int j = 0; j < 8; j++) b = {b[55:0], p[8*k+j]};
      push_exp(b, (k == p.size() / 8 - 1), n);
    end
  endtask

  // Monitor: hold check on stalls, random/forced back-pressure, scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      m_ready    = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 64'(m_valid), 64'(1));
        check_eq("hold_block", m_block, prev_blk);
        check_eq("hold_last", 64'(m_last), 64'(prev_last));
      end
      case (ready_mode)
        1:       m_ready = 1'b1;
        2:       m_ready = 1'b0;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_block", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          check_eq("block", m_block, e.blk);
          check_eq("last", 64'(m_last), 64'(e.last));
          if (e.last) begin
`ifdef ASCON_PAD_LEN_EN
            check_eq("msg_bytes", 64'(msg_bytes), 64'(e.len));
`else
            check_eq("msg_bytes", 64'(msg_bytes), 64'(0));
`endif
            check_eq("len_ovf", 64'(len_ovf), 64'(0));
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_blk   = m_block;
      prev_last  = m_last;
    end
  end

  // Present one beat (called at a negedge) and hold it until accepted.
  task automatic drive_beat(input logic [7:0] d, input logic l, input logic e);
    int waited = 0;
    s_data  = d;
    s_last  = l;
    s_empty = e;
    s_valid = 1'b1;
    while (!s_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) check_eq("beat_timeout", 64'(waited), 64'(0));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_empty = 1'b0;
  endtask

  // Send msg_q; closing either on the last data byte or with an empty beat.
  task automatic send_msg(input bit empty_last, input bit gaps);
    int n;
    n = msg_q.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) repeat ($urandom_range(1, 2)) @(negedge clk);
      if (gaps && ($urandom_range(0, 7) == 0)) drive_beat(8'($urandom), 1'b0, 1'b1);
      drive_beat(msg_q[i], (i == n - 1) && !empty_last, 1'b0);
    end
    if (empty_last || n == 0) drive_beat(8'($urandom), 1'b1, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_s_ready"}, 64'(s_ready), 64'(1));
    check_eq({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    check_eq({tag, "_m_block"}, m_block, 64'(0));
    check_eq({tag, "_m_last"}, 64'(m_last), 64'(0));
    check_eq({tag, "_msg_bytes"}, 64'(msg_bytes), 64'(0));
    check_eq({tag, "_len_ovf"}, 64'(len_ovf), 64'(0));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // "abc"
    push_exp(64'h6162638000000000, 1'b1, 3);
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, 1'b0);
    wait_drain();

    // Exactly one block of data: a pad-only block follows.
    push_exp(64'h0102030405060708, 1'b0, 8);
    push_exp(64'h8000000000000000, 1'b1, 8);
    msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_msg(1'b0, 1'b0);
    wait_drain();

    // Zero-length message.
    push_exp(64'h8000000000000000, 1'b1, 0);
    msg_q = {};
    send_msg(1'b1, 1'b0);
    wait_drain();

    // Ten bytes 00..09.
    push_exp(64'h0001020304050607, 1'b0, 10);
    push_exp(64'h0809800000000000, 1'b1, 10);
    msg_q = {};
    for (int i = 0; i < 10; i++) msg_q.push_back(8'(i));
    send_msg(1'b0, 1'b0);
    wait_drain();

    // Back-pressure: hold m_ready low for 5 cycles while a block waits.
    ready_mode = 2;
    push_exp(64'h6162638000000000, 1'b1, 3);
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, 1'b0);
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_m_valid", 64'(m_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_s_ready", 64'(s_ready), 64'(0));
      check_eq("stall_block", m_block, 64'h6162638000000000);
    end
    ready_mode = 1;
    wait_drain();
    ready_mode = 0;

    // Reset after 5 of 8 bytes drops the partial block.
    for (int i = 0; i < 5; i++) drive_beat(8'(8'hA0 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst_rel");
    push_exp(64'h6162638000000000, 1'b1, 3);
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, 1'b0);
    wait_drain();

    // Random messages against the model.
    for (int m = 0; m < 24; m++) begin
      msg_q = {};
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      model_msg();
      send_msg(bit'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
